// File: rtl/multi_cycle_control.sv
// Multi-cycle LEGv8 control FSM: sequences the shared datapath through
// FETCH/DECODE/EXEC/MEM/WB and traps on undefined opcodes or memory timeouts.
module multi_cycle_control #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TO_W        = 8
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [10:0] opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        ir_write,
  output logic        addr_sel,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        reg2loc,
  output logic        mem_to_reg,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [3:0]  alu_op,
  output logic [1:0]  sign_op,
  output logic        pc_src,
  output logic        illegal,
  output logic        bus_err,
  output logic        instr_done
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    I_AND, I_ORR, I_ADD, I_SUB, I_ADDI, I_SUBI,
    I_MOVZ, I_B, I_CBZ, I_LDUR, I_STUR, I_ILL
  } instr_t;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_ORR  = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_PASS = 4'b0111;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_REG   = 2'b01;
  localparam logic [1:0] SRC_A_OLDPC = 2'b10;

  localparam logic [1:0] SRC_B_REG   = 2'b00;
  localparam logic [1:0] SRC_B_FOUR  = 2'b01;
  localparam logic [1:0] SRC_B_IMM   = 2'b10;
  localparam logic [1:0] SRC_B_BOFS  = 2'b11;

  localparam logic [1:0] SEXT_I  = 2'b00;
  localparam logic [1:0] SEXT_D  = 2'b01;
  localparam logic [1:0] SEXT_CB = 2'b10;
  localparam logic [1:0] SEXT_B  = 2'b11;

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

  state_t            state_q, state_d;
  logic [TO_W-1:0]   count_q, count_d;
  logic              illegal_q, illegal_d;
  logic              bus_err_q, bus_err_d;
  logic              mem_wait;
  instr_t            instr;

  always_comb begin
    instr = I_ILL;
    casez (opcode)
      11'b10001010000: instr = I_AND;
      11'b10101010000: instr = I_ORR;
      11'b10001011000: instr = I_ADD;
      11'b11001011000: instr = I_SUB;
      11'b1001000100?: instr = I_ADDI;
      11'b1101000100?: instr = I_SUBI;
      11'b110100101??: instr = I_MOVZ;
      11'b000101?????: instr = I_B;
      11'b10110100???: instr = I_CBZ;
      11'b11111000010: instr = I_LDUR;
      11'b11111000000: instr = I_STUR;
      default:         instr = I_ILL;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    bus_err_d  = bus_err_q;
    mem_wait   = 1'b0;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    addr_sel   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg2loc    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_REG;
    alu_op     = ALU_AND;
    sign_op    = SEXT_I;
    pc_src     = 1'b0;
    instr_done = 1'b0;

    // Reset overrides every output so an aborted instruction writes nothing.
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_a = SRC_A_PC;
          alu_src_b = SRC_B_FOUR;
          alu_op    = ALU_ADD;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end else if (count_q == TO_LIMIT) begin
            bus_err_d = 1'b1;
            state_d   = S_TRAP;
          end else begin
            mem_wait = 1'b1;
          end
        end

        S_DECODE: begin
          alu_src_a = SRC_A_OLDPC;
          alu_src_b = SRC_B_BOFS;
          alu_op    = ALU_ADD;
          if (instr == I_CBZ) sign_op = SEXT_CB;
          if (instr == I_B)   sign_op = SEXT_B;
          reg2loc = (instr == I_STUR) || (instr == I_CBZ);
          if (instr == I_ILL) begin
            illegal_d = 1'b1;
            state_d   = S_TRAP;
          end else begin
            state_d = S_EXEC;
          end
        end

        S_EXEC: begin
          case (instr)
            I_AND, I_ORR, I_ADD, I_SUB: begin
              alu_src_a = SRC_A_REG;
              alu_src_b = SRC_B_REG;
              case (instr)
                I_AND:   alu_op = ALU_AND;
                I_ORR:   alu_op = ALU_ORR;
                I_SUB:   alu_op = ALU_SUB;
                default: alu_op = ALU_ADD;
              endcase
              state_d = S_WB;
            end
            I_ADDI, I_SUBI: begin
              alu_src_a = SRC_A_REG;
              alu_src_b = SRC_B_IMM;
              sign_op   = SEXT_I;
              alu_op    = (instr == I_SUBI) ? ALU_SUB : ALU_ADD;
              state_d   = S_WB;
            end
            I_MOVZ: begin
              alu_src_b = SRC_B_IMM;
              sign_op   = SEXT_I;
              alu_op    = ALU_PASS;
              state_d   = S_WB;
            end
            I_LDUR, I_STUR: begin
              alu_src_a = SRC_A_REG;
              alu_src_b = SRC_B_IMM;
              sign_op   = SEXT_D;
              alu_op    = ALU_ADD;
              reg2loc   = (instr == I_STUR);
              state_d   = S_MEM;
            end
            I_CBZ: begin
              reg2loc    = 1'b1;
              alu_src_a  = SRC_A_REG;
              alu_src_b  = SRC_B_REG;
              alu_op     = ALU_PASS;
              pc_src     = 1'b1;
              pc_write   = zero;
              instr_done = 1'b1;
              state_d    = S_FETCH;
            end
            I_B: begin
              pc_src     = 1'b1;
              pc_write   = 1'b1;
              instr_done = 1'b1;
              state_d    = S_FETCH;
            end
            default: begin
              illegal_d = 1'b1;
              state_d   = S_TRAP;
            end
          endcase
        end

        S_MEM: begin
          addr_sel = 1'b1;
          if (instr == I_STUR) mem_write = 1'b1;
          else                 mem_read  = 1'b1;
          if (mem_ready) begin
            if (instr == I_STUR) begin
              instr_done = 1'b1;
              state_d    = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end else if (count_q == TO_LIMIT) begin
            bus_err_d = 1'b1;
            state_d   = S_TRAP;
          end else begin
            mem_wait = 1'b1;
          end
        end

        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (instr == I_LDUR);
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end

        S_TRAP: state_d = S_TRAP;

        default: state_d = S_TRAP;
      endcase
    end
  end

  always_comb begin
    count_d = count_q;
    if (state_d != state_q) count_d = '0;
    else if (mem_wait)      count_d = count_q + TO_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= S_FETCH;
      count_q   <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign illegal = illegal_q;
  assign bus_err = bus_err_q;

endmodule

// File: doc/multi_cycle_control.md
Name: multi_cycle_control

Overview:
- Multi-cycle LEGv8 control FSM. Sequences a shared datapath (one ALU, one unified memory port, register file, PC/OldPC/IR/A/B/ALUOut/MDR registers) through FETCH/DECODE/EXEC/MEM/WB.
- Replaces per-instruction combinational control when the processor moves to the multi-cycle, variable-memory-latency build.
- Decodes the same 11-bit opcode set: ANDREG, ORRREG, ADDREG, SUBREG, ADDIMM, SUBIMM, MOVZ, B, CBZ, LDUR, STUR.

Parameters:
- MEM_TIMEOUT, 255: maximum cycles to wait for mem_ready in FETCH or MEM before trapping.
- TO_W, 8: width of the timeout counter. Must satisfy 2^TO_W > MEM_TIMEOUT.

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high; highest priority.
- opcode  in  11  IR[31:21], valid from DECODE onward.
- zero  in  1  ALU zero flag (combinational from current ALU inputs).
- mem_ready  in  1  memory port completion for the current access.
- pc_write  out  1  PC load enable.
- ir_write  out  1  IR and OldPC load enable.
- addr_sel  out  1  memory address: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- reg_write  out  1  register file write enable.
- reg2loc  out  1  0=Rm, 1=Rt for read port 2.
- mem_to_reg  out  1  write-back source: 0=ALUOut, 1=MDR.
- alu_src_a  out  2  00=PC, 01=A, 10=OldPC.
- alu_src_b  out  2  00=B, 01=const 4, 10=extended immediate, 11=branch offset shifted left 2.
- alu_op  out  4  0000 AND, 0001 ORR, 0010 ADD, 0110 SUB, 0111 pass-B.
- sign_op  out  2  00 I/MOVZ, 01 D, 10 CB, 11 B.
- pc_src  out  1  PC input: 0=ALU result, 1=ALUOut.
- illegal  out  1  sticky trap flag: undefined opcode.
- bus_err  out  1  sticky trap flag: memory timeout.
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction.

Behaviour:
- State encoding (3 bits): FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Output register policy: outputs are Moore/Mealy combinational from state, opcode, zero and mem_ready. Only state, timeout count, illegal and bus_err are registered.
- Reset: state=FETCH, count=0, illegal=0, bus_err=0. With reset high, every enable output (pc_write, ir_write, mem_read, mem_write, reg_write, instr_done) is 0 and all select fields are 0. Reset mid-instruction aborts it; no write enable is asserted in the reset cycle.
- Defaults in every state: all outputs 0 unless listed below.
- FETCH:
  - Drive mem_read=1, addr_sel=0, alu_src_a=00, alu_src_b=01, alu_op=ADD.
  - If mem_ready: ir_write=1, pc_write=1 (pc_src=0, loads PC+4), go to DECODE.
  - Otherwise stay in FETCH and increment count.
- DECODE:
  - Drive alu_src_a=10, alu_src_b=11, alu_op=ADD; ALUOut captures the branch target.
  - sign_op=10 for CBZ, 11 for B.
  - reg2loc=1 for STUR and CBZ.
  - Undefined opcode: go to TRAP and set illegal. Otherwise go to EXEC.
- EXEC, R-type (AND, ORR, ADD, SUB):
  - alu_src_a=01, alu_src_b=00, alu_op per opcode, then go to WB.
- EXEC, ADDIMM/SUBIMM:
  - alu_src_a=01, alu_src_b=10, sign_op=00, alu_op per opcode, then go to WB.
- EXEC, MOVZ:
  - alu_src_b=10, sign_op=00, alu_op=0111, then go to WB.
- EXEC, LDUR/STUR:
  - alu_src_a=01, alu_src_b=10, sign_op=01, alu_op=ADD, then go to MEM.
  - reg2loc=1 for STUR.
- EXEC, CBZ:
  - reg2loc=1, alu_src_a=01, alu_src_b=00, alu_op=0111, pc_src=1.
  - pc_write=zero.
  - instr_done=1, then go to FETCH.
- EXEC, B:
  - pc_src=1, pc_write=1, instr_done=1, then go to FETCH.
- MEM:
  - addr_sel=1. LDUR drives mem_read=1; STUR drives mem_write=1.
  - Hold the request until mem_ready.
  - On mem_ready: LDUR goes to WB; STUR asserts instr_done=1 and goes to FETCH.
- WB:
  - reg_write=1. mem_to_reg=1 for LDUR, else 0.
  - instr_done=1, then go to FETCH.
- Timeout counter:
  - Cleared on every state change.
  - Counts cycles spent in FETCH or MEM with mem_ready=0.
  - When count reaches MEM_TIMEOUT with mem_ready still 0: set bus_err and go to TRAP. mem_ready in that same cycle wins over the timeout.
- TRAP:
  - All enables 0 and instr_done=0.
  - Absorbing; only reset exits it.
- mem_ready is ignored outside FETCH and MEM.
- Latency with mem_ready already high:
  - R/I/MOVZ: 4 cycles.
  - LDUR: 5 cycles.
  - STUR: 4 cycles.
  - CBZ/B: 3 cycles.
- Latency with memory wait states: add one cycle per wait cycle in FETCH and in MEM.

Test Plan:
- Reset, then ADDREG (opcode 10001011000) with mem_ready=1 → states FETCH, DECODE, EXEC, WB. reg_write=1 and instr_done=1 only in cycle 4; alu_op=0010 in EXEC.
- LDUR (11111000010), mem_ready low for 3 cycles in MEM → mem_read and addr_sel=1 held 4 cycles. WB asserts reg_write=1 and mem_to_reg=1. Total 8 cycles.
- CBZ (10110100xxx): zero=1 → pc_write=1 and pc_src=1 in EXEC. Repeat with zero=0 → pc_write=0. Both end in FETCH after 3 cycles.
- Opcode 00000000000 → TRAP after DECODE, illegal=1, all enables 0 for 20 cycles. reset → FETCH with illegal=0.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=4 → bus_err=1 and TRAP after 5 FETCH cycles. Repeat with mem_ready rising on the timeout cycle → DECODE, bus_err=0.
- Assert reset in MEM of STUR (11111000000) → mem_write=0 in the reset cycle, FETCH on the next edge, no instr_done.
